mem_access: RTL and testbench

Byte-serial data-memory access unit for the Y86-64 core, sitting downstream of the execute stage: it consumes the execute results (valE) and the register operands (valA, valP) of the current instruction and performs the quadword load or store that instruction requires. Each 64-bit access is split into eight little-endian byte transfers over a req/ack byte port, so memories of any latency can be attached. It returns valM to writeback and flags out-of-range addresses as a data-memory error.

---
 rtl/y86_pkg.sv | 47 ++++
 rtl/mem_access.sv | 113 +++++++++++
 tb/tb_mem_access.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the data-memory access path: icodes, the access
// FSM state type, and the quadword decode / range-check helpers.
package y86_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    // acc: instruction touches memory; we: store; addr_a: address comes from
    // valA instead of valE; data_p: store data comes from valP instead of valA.
    typedef struct packed {
        logic acc;
        logic we;
        logic addr_a;
        logic data_p;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] icode);
        dec_t d;
        d = '0;
        unique case (icode)
            IMRMOVQ:       d.acc = 1'b1;
            IRET, IPOPQ:   begin d.acc = 1'b1; d.addr_a = 1'b1; end
            IRMMOVQ,
            IPUSHQ:        begin d.acc = 1'b1; d.we = 1'b1; end
            ICALL:         begin d.acc = 1'b1; d.we = 1'b1; d.data_p = 1'b1; end
            default:       d = '0;
        endcase
        return d;
    endfunction

    // The whole quadword must fit: the last byte is base+7 < limit.
    function automatic logic in_range(input logic [63:0] base,
                                      input logic [63:0] limit);
        return base <= (limit - 64'd8);
    endfunction

endpackage

// File: rtl/mem_access.sv
// Byte-serial Y86-64 data-memory stage: splits each quadword load/store into
// eight little-endian req/ack byte transfers and reports valM / dmem_error.
module mem_access
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valP_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] valM_o,
    output logic        dmem_error_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] base_q, base_d;
    logic [63:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [63:0] valm_q, valm_d;
    logic        err_q, err_d;

    dec_t        dec_w;
    logic [63:0] addr_w;
    logic [63:0] data_w;
    logic [5:0]  lane_w;
    logic        xfer_w;

    assign dec_w  = decode(icode_i);
    assign addr_w = dec_w.addr_a ? valA_i : valE_i;
    assign data_w = dec_w.data_p ? valP_i : valA_i;
    assign lane_w = {idx_q, 3'b000};
    assign xfer_w = (state_q == XFER);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        valm_d  = valm_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    valm_d  = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = DONE;
                    if (dec_w.acc) begin
                        base_d  = addr_w;
                        wdata_d = data_w;
                        we_d    = dec_w.we;
                        if (in_range(addr_w, 64'(ADDR_LIMIT))) state_d = XFER;
                        else                                     err_d   = 1'b1;
                    end
                end
            end
            XFER: begin
                if (mem_ack_i) begin
                    if (!we_q) valm_d[lane_w +: 8] = mem_rdata_i;
                    if (idx_q == 3'd7) state_d = DONE;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            valm_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            valm_q  <= valm_d;
            err_q   <= err_d;
        end
    end

    // Byte-port outputs are gated so the bus reads all-zero outside a transfer.
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign valM_o       = valm_q;
    assign dmem_error_o = err_q;
    assign mem_req_o    = xfer_w;
    assign mem_we_o     = xfer_w & we_q;
    assign mem_addr_o   = xfer_w ? (base_q + {61'd0, idx_q}) : '0;
    assign mem_wdata_o  = xfer_w ? wdata_q[lane_w +: 8] : '0;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte memory responder plus a quadword-level model that
// predicts every transfer, the done cycle, valM and dmem_error.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  icode_i = '0;
    logic [63:0] valE_i = '0, valA_i = '0, valP_i = '0;
    logic        busy_o, done_o, dmem_error_o, mem_req_o, mem_we_o;
    logic [63:0] valM_o, mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;

    mem_access #(.ADDR_LIMIT(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .icode_i(icode_i),
        .valE_i(valE_i), .valA_i(valA_i), .valP_i(valP_i),
        .busy_o(busy_o), .done_o(done_o), .valM_o(valM_o),
        .dmem_error_o(dmem_error_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    always #5 clk = ~clk;

    logic [7:0]  tb_mem [0:1023];
    int          n_cmp = 0, n_err = 0;

    // model state for the transaction in flight
    bit          active = 0;
    int          cyc = 0, exp_done = 1, nacks = 0, done_cyc = -1;
    int          period = 1, ack_cnt = 0;
    bit          ack_idle = 0;
    bit          exp_xfer = 0, exp_rd = 0, exp_we = 0, exp_err = 0;
    logic [63:0] exp_base = '0, exp_wd = '0, exp_valm = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // compare process + memory responder
    always @(negedge clk) begin
        bit ack;
        if (!rst_n) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else begin
            if (active) begin
                cyc++;
                chk("busy", 64'(busy_o), 64'd1);
                chk("done", 64'(done_o), 64'(cyc == exp_done));
                chk("mem_req", 64'(mem_req_o), 64'(exp_xfer && cyc < exp_done));
                chk("dmem_error", 64'(dmem_error_o), 64'(exp_err));
                if (!exp_rd || cyc == exp_done) chk("valM", valM_o, exp_valm);
                if (cyc == exp_done) begin
                    done_cyc = cyc;
                    active   = 0;
                end
            end else begin
                chk("idle busy", 64'(busy_o), 64'd0);
                chk("idle done", 64'(done_o), 64'd0);
                chk("idle mem_req", 64'(mem_req_o), 64'd0);
                chk("held valM", valM_o, exp_valm);
                chk("held dmem_error", 64'(dmem_error_o), 64'(exp_err));
            end
            if (mem_req_o) begin
                ack     = (ack_cnt == period - 1);
                ack_cnt = ack ? 0 : ack_cnt + 1;
            end else begin
                ack     = ack_idle;
                ack_cnt = 0;
            end
            mem_ack   = ack;
            mem_rdata = tb_mem[mem_addr_o[9:0]];
            if (ack && mem_req_o) begin
                if (active && nacks < 8) begin
                    chk("mem_addr", mem_addr_o, exp_base + 64'(nacks));
                    chk("mem_we", 64'(mem_we_o), 64'(exp_we));
                    if (exp_we) chk("mem_wdata", 64'(mem_wdata_o), 64'(exp_wd[8*nacks +: 8]));
                end
                nacks++;
                if (mem_we_o) tb_mem[mem_addr_o[9:0]] = mem_wdata_o;
            end
        end
    end

    // One instruction: model predicts from the decode rules, then waits
    // (bounded) for completion. poke re-pulses start while busy; abort_after
    // pulls reset once that many bytes have been acked.
    task automatic run(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input int per, input bit poke, input int abort_after);
        logic [63:0] base, data;
        bit acc, we;
        acc = 1; we = 0; base = e; data = '0;
        case (ic)
            4'h5:       ;
            4'h9, 4'hB: base = a;
            4'h4, 4'hA: begin we = 1; data = a; end
            4'h8:       begin we = 1; data = p; end
            default:    acc = 0;
        endcase
        @(negedge clk); #1;
        period   = per;
        exp_base = base;
        exp_we   = we;
        exp_wd   = data;
        exp_err  = acc && (base > 64'd1016);
        exp_xfer = acc && !exp_err;
        exp_rd   = exp_xfer && !we;
        exp_done = exp_xfer ? 8 * per + 1 : 1;
        exp_valm = '0;
        if (exp_rd) for (int i = 0; i < 8; i++) exp_valm[8*i +: 8] = tb_mem[int'(base[9:0]) + i];
        nacks = 0; cyc = 0; done_cyc = -1; active = 1;
        start_i = 1; icode_i = ic; valE_i = e; valA_i = a; valP_i = p;
        @(posedge clk); #1;
        start_i = 0; icode_i = 4'hF; valE_i = '1; valA_i = 64'h3F9; valP_i = '1;
        for (int k = 0; k < 300 && active; k++) begin
            @(negedge clk); #1;
            start_i = 0;
            if (poke && cyc == 4) begin start_i = 1; icode_i = 4'hB; end
            if (abort_after > 0 && nacks == abort_after) begin
                @(posedge clk); #2;
                rst_n = 0; active = 0;
                #1;
                chk("abort busy", 64'(busy_o), 64'd0);
                chk("abort done", 64'(done_o), 64'd0);
                chk("abort mem_req", 64'(mem_req_o), 64'd0);
                chk("abort mem_we", 64'(mem_we_o), 64'd0);
                chk("abort mem_addr", mem_addr_o, 64'd0);
                chk("abort mem_wdata", 64'(mem_wdata_o), 64'd0);
                chk("abort valM", valM_o, 64'd0);
                chk("abort dmem_error", 64'(dmem_error_o), 64'd0);
                exp_valm = '0; exp_err = 0;
                @(negedge clk); #1;
                rst_n = 1;
            end
        end
        start_i = 0;
        if (active) begin
            chk("timeout waiting for done", 64'd1, 64'd0);
            active = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 8; i++) tb_mem[16 + i] = 8'(i + 1);
        #12;
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset done", 64'(done_o), 64'd0);
        chk("reset valM", valM_o, 64'd0);
        chk("reset dmem_error", 64'(dmem_error_o), 64'd0);
        chk("reset mem_req", 64'(mem_req_o), 64'd0);
        chk("reset mem_addr", mem_addr_o, 64'd0);
        @(negedge clk); #1;
        rst_n = 1;

        // mrmovq, zero-wait
        run(4'h5, 64'h10, 64'h0, 64'h0, 1, 0, 0);
        chk("mrmovq valM", valM_o, 64'h0807060504030201);
        chk("mrmovq latency", 64'(done_cyc), 64'd9);

        // pushq at top of memory, ack every 3rd cycle
        run(4'hA, 64'h3F8, 64'h1122334455667788, 64'h0, 3, 0, 0);
        chk("pushq latency", 64'(done_cyc), 64'd25);
        chk("pushq mem", {tb_mem[1023], tb_mem[1022], tb_mem[1021], tb_mem[1020],
                          tb_mem[1019], tb_mem[1018], tb_mem[1017], tb_mem[1016]},
            64'h1122334455667788);

        // ret one past the last valid base -> error
        run(4'h9, 64'h0, 64'h3F9, 64'h0, 1, 0, 0);
        chk("ret err", 64'(dmem_error_o), 64'd1);
        chk("ret valM", valM_o, 64'd0);
        chk("ret latency", 64'(done_cyc), 64'd1);

        // address near 2^64 must not wrap into range
        run(4'h4, 64'hFFFF_FFFF_FFFF_FFF9, 64'h55, 64'h0, 1, 0, 0);
        chk("rmmovq huge err", 64'(dmem_error_o), 64'd1);

        // irmovq: no access, ack held high while idle is ignored
        ack_idle = 1;
        run(4'h3, 64'h20, 64'h20, 64'h0, 1, 0, 0);
        ack_idle = 0;
        chk("irmovq latency", 64'(done_cyc), 64'd1);
        chk("irmovq err", 64'(dmem_error_o), 64'd0);

        // load with waits, start re-pulsed while busy
        run(4'h5, 64'h20, 64'h0, 64'h0, 2, 1, 0);
        chk("busy-start valM", valM_o, 64'h7D7C7F7E79787B7A);
        chk("busy-start latency", 64'(done_cyc), 64'd17);

        // store then read back; popq at last valid base
        run(4'h4, 64'h40, 64'hCAFEF00DDEADBEEF, 64'h0, 1, 0, 0);
        run(4'hB, 64'h0, 64'h40, 64'h0, 2, 0, 0);
        chk("popq readback", valM_o, 64'hCAFEF00DDEADBEEF);
        run(4'hB, 64'h0, 64'h3F8, 64'h0, 1, 0, 0);
        chk("popq boundary", valM_o, 64'h1122334455667788);

        // call aborted by reset after 3 bytes, then read the partial result
        run(4'h8, 64'h100, 64'h0, 64'hABCD, 1, 0, 3);
        run(4'h5, 64'h100, 64'h0, 64'h0, 1, 0, 0);
        chk("post-abort valM", valM_o, 64'h5D5C5F5E5900ABCD);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
